// File: rtl/mac_sat_ctrl.sv
// mac_sat_ctrl: sequences a programmed-length Q17.14 x Q1.14 saturating MAC job and emits a saturated Q17.14 result
//   i_clk, i_rst_n        clock, async active-low reset
//   i_start, i_len        job start pulse and beat count (sampled in IDLE)
//   i_valid/o_ready       operand handshake, i_a (Q17.14) and i_b (Q1.14)
//   o_valid/i_ready       result handshake, o_data (Q17.14) and o_sat (job saturated)
//   o_busy                high whenever not IDLE
module mac_sat_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_a,
  input  logic [15:0]      i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_data,
  output logic             o_sat,
  output logic             o_busy
);
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
  state_t state, state_nx;
  logic [47:0] acc, acc_sum;
  logic [LEN_W-1:0] count;
  logic sat, sat_nx;
  logic signed [47:0] prod;
  logic [48:0] sum;
  logic ovf, beat, last, cvt_ok;
  logic [31:0] cvt_data;
  assign prod = $signed({{16{i_a[31]}}, i_a}) * $signed({{32{i_b[15]}}, i_b});
  assign sum = {acc[47], acc} + {prod[47], prod};
  // a 49-bit sum outside 48-bit range shows up as differing top two bits
  assign ovf = sum[48] ^ sum[47];
  assign acc_sum = ovf ? (sum[48] ? 48'h8000_0000_0000 : 48'h7FFF_FFFF_FFFF) : sum[47:0];
  assign o_ready = state == ACC;
  assign o_valid = state == OUT;
  assign o_busy = state != IDLE;
  assign beat = i_valid && o_ready;
  assign last = beat && count == LEN_W'(1);
  // result fits Q17.14 only when the bits above bit 45 are pure sign extension
  assign cvt_ok = acc_sum[47:45] == 3'b000 || acc_sum[47:45] == 3'b111;
  assign cvt_data = cvt_ok ? acc_sum[45:14] : (acc_sum[47] ? 32'h8000_0000 : 32'h7FFF_FFFF);
  assign sat_nx = sat | ovf | (last & ~cvt_ok);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = i_start ? (i_len == '0 ? OUT : ACC) : IDLE;
      ACC:  state_nx = last ? OUT : ACC;
      OUT:  state_nx = i_ready ? IDLE : OUT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      acc <= '0;
      count <= '0;
      sat <= 1'b0;
      o_data <= '0;
      o_sat <= 1'b0;
    end else if (state == IDLE && i_start) begin
      acc <= '0;
      sat <= 1'b0;
      count <= i_len;
      if (i_len == '0) begin
        o_data <= '0;
        o_sat <= 1'b0;
      end
    end else if (beat) begin
      acc <= acc_sum;
      sat <= sat_nx;
      count <= count - LEN_W'(1);
      if (last) begin
        o_data <= cvt_data;
        o_sat <= sat_nx;
      end
    end
endmodule

// File: tb/tb_mac_sat_ctrl.sv
// tb_mac_sat_ctrl: directed self-checking bench for mac_sat_ctrl
module tb_mac_sat_ctrl;
  logic clk = 0, rst_n = 0, start = 0, valid = 0, ready = 0;
  logic [7:0] len = 0;
  logic [31:0] a = 0;
  logic [15:0] b = 0;
  logic o_ready, o_valid, o_sat, o_busy;
  logic [31:0] o_data;
  int checks = 0, errors = 0;

  mac_sat_ctrl #(.LEN_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len),
    .i_valid(valid), .o_ready(o_ready), .i_a(a), .i_b(b),
    .o_valid(o_valid), .i_ready(ready), .o_data(o_data), .o_sat(o_sat), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] l);
    start = 1; len = l;
    step();
    start = 0;
  endtask

  task automatic do_beat(input logic [31:0] av, input logic [15:0] bv);
    valid = 1; a = av; b = bv;
    step();
    valid = 0;
  endtask

  task automatic take(input string name, input logic [31:0] exp_d, input logic exp_s);
    checks++;
    if (o_valid !== 1'b1) begin errors++; $display("FAIL %s valid got %b exp 1", name, o_valid); end
    checks++;
    if (o_data !== exp_d) begin errors++; $display("FAIL %s data got %h exp %h", name, o_data, exp_d); end
    checks++;
    if (o_sat !== exp_s) begin errors++; $display("FAIL %s sat got %b exp %b", name, o_sat, exp_s); end
    ready = 1;
    step();
    ready = 0;
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL %s idle got valid %b busy %b exp 0 0", name, o_valid, o_busy); end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({o_ready, o_valid, o_busy, o_sat, o_data} !== 36'h0) begin errors++; $display("FAIL reset outputs got %h exp 0", {o_ready, o_valid, o_busy, o_sat, o_data}); end
    #5 rst_n = 1;
    step();
  endtask

  task automatic test_nominal();
    do_start(2);
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b1) begin errors++; $display("FAIL nominal acc_state got ready %b busy %b exp 1 1", o_ready, o_busy); end
    do_beat(32'h0000_4000, 16'h4000);
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL nominal early_valid got %b exp 0", o_valid); end
    do_beat(32'h0000_4000, 16'h4000);
    checks++;
    if (o_ready !== 1'b0) begin errors++; $display("FAIL nominal out_ready got %b exp 0", o_ready); end
    take("nominal", 32'h0000_8000, 1'b0);
  endtask

  task automatic test_negative();
    do_start(1);
    do_beat(32'h0000_4000, 16'hC000);
    take("negative", 32'hFFFF_C000, 1'b0);
  endtask

  task automatic test_conv_sat();
    do_start(1);
    do_beat(32'h7FFF_FFFF, 16'h7FFF);
    take("conv_pos", 32'h7FFF_FFFF, 1'b1);
    do_start(1);
    do_beat(32'h8000_0000, 16'h7FFF);
    take("conv_neg", 32'h8000_0000, 1'b1);
  endtask

  task automatic test_acc_clamp();
    do_start(4);
    for (int i = 0; i < 4; i++) do_beat(32'h8000_0000, 16'h8000);
    take("acc_clamp", 32'h7FFF_FFFF, 1'b1);
  endtask

  task automatic test_floor_empty();
    do_start(1);
    do_beat(32'hFFFF_FFFF, 16'h0001);
    take("floor", 32'hFFFF_FFFF, 1'b0);
    do_start(0);
    take("empty", 32'h0000_0000, 1'b0);
  endtask

  task automatic test_handshake();
    logic [3:0] pat;
    pat = 4'b1101;
    do_start(3);
    a = 32'h0000_4000; b = 16'h4000;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_ready !== 1'b1) begin errors++; $display("FAIL handshake ready_%0d got %b exp 1", i, o_ready); end
      valid = pat[i];
      step();
    end
    valid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== 32'h0000_C000) begin errors++; $display("FAIL handshake hold_%0d got valid %b data %h exp 1 0000c000", i, o_valid, o_data); end
      start = 1; len = 5; valid = 1;
      step();
    end
    start = 0; valid = 0;
    take("handshake", 32'h0000_C000, 1'b0);
  endtask

  task automatic test_mid_reset();
    do_start(4);
    do_beat(32'h7FFF_0000, 16'h4000);
    do_beat(32'h7FFF_0000, 16'h4000);
    rst_n = 0;
    #1;
    checks++;
    if ({o_ready, o_valid, o_busy, o_sat, o_data} !== 36'h0) begin errors++; $display("FAIL mid_reset outputs got %h exp 0", {o_ready, o_valid, o_busy, o_sat, o_data}); end
    #3 rst_n = 1;
    step();
    do_start(1);
    do_beat(32'h0000_4000, 16'h4000);
    take("after_reset", 32'h0000_4000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_negative();
    test_conv_sat();
    test_acc_clamp();
    test_floor_empty();
    test_handshake();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_sat_ctrl.md
Name: mac_sat_ctrl

Overview:
- Sequencing controller for the fixed-point multiply-accumulate path.
- Accepts a programmed-length stream of operand pairs over a valid/ready handshake.
- Multiplies each pair (Q17.14 sample × Q1.14 coefficient), accumulates into a 48-bit saturating accumulator, then truncates and saturates the result to a Q17.14 32-bit word.
- Presents the result on a valid/ready output port; sits between the sample buffer and the downstream filter/writeback stage.

Parameters:
- LEN_W, 8, width of the per-job beat count. Maximum job length is 2^LEN_W-1 beats.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  job start pulse; sampled only in IDLE.
- i_len  input  LEN_W  number of operand beats; sampled with i_start.
- i_valid  input  1  operand pair valid.
- o_ready  output  1  controller accepts an operand pair.
- i_a  input  32  signed sample, Q17.14.
- i_b  input  16  signed coefficient, Q1.14.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_data  output  32  signed result, Q17.14.
- o_sat  output  1  saturation occurred anywhere in this job; valid with o_valid.
- o_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, i_rst_n=0) values: state=IDLE, acc=0, count=0, sat flag=0, o_ready=0, o_valid=0, o_data=0, o_sat=0, o_busy=0. Reset mid-job aborts the job with no output.
- FSM states: IDLE, ACC, OUT.
- IDLE:
  - On i_start=1 with i_len!=0: clear acc and sat flag, load count=i_len, go to ACC.
  - On i_start=1 with i_len==0: clear acc and sat flag, go to OUT; result is 0 with o_sat=0.
- ACC:
  - o_ready=1.
  - A beat is accepted when i_valid && o_ready.
  - prod = i_a × i_b as a signed 48-bit value with 28 fractional bits; exact, no overflow possible.
  - sum = acc + prod, computed in 49 bits. If sum exceeds 48-bit signed range, acc clamps to 0x7FFF_FFFF_FFFF or 0x8000_0000_0000 and the sat flag is set. The flag is sticky for the job.
  - count decrements on each accepted beat. On the beat where count==1, go to OUT next cycle.
  - No bubble: back-to-back beats are accepted every cycle.
- OUT:
  - o_ready=0; o_valid=1 on the first OUT cycle, i.e. one cycle after the last accepted beat.
  - Output conversion:
    - If acc[47:45] is all-0 or all-1: o_data = acc[45:14] (arithmetic truncation, floor).
    - Otherwise: o_data = 0x7FFF_FFFF if acc[47]=0, else 0x8000_0000, and the sat flag is set.
  - o_sat = sticky flag OR conversion saturation.
  - o_data and o_sat are registered and held stable while i_ready=0.
  - On i_valid... no: on o_valid && i_ready, go to IDLE; o_valid drops next cycle.
- i_start outside IDLE is ignored. i_valid outside ACC is ignored; no beat is consumed.
- o_data holds its last value in IDLE; it is meaningful only with o_valid.
- Minimum job turnaround: 1 (start) + len (beats) + 1 (output) cycles, plus any backpressure.

Test Plan:
- Nominal: len=2, two beats of a=0x0000_4000, b=0x4000 (1.0×1.0) -> acc=0x2000_0000; o_data=0x0000_8000 (2.0), o_sat=0; o_valid exactly 1 cycle after the 2nd beat.
- Conversion saturation: len=1, a=0x7FFF_FFFF, b=0x7FFF -> o_data=0x7FFF_FFFF, o_sat=1. Same with a=0x8000_0000 -> o_data=0x8000_0000, o_sat=1.
- Accumulator clamp: len=4, a=0x8000_0000, b=0x8000 (+2^46 each beat) -> acc clamps at 0x7FFF_FFFF_FFFF after the 2nd beat; o_data=0x7FFF_FFFF, o_sat=1.
- Floor truncation and empty job:
  - len=1, a=0xFFFF_FFFF, b=0x0001 -> o_data=0xFFFF_FFFF, o_sat=0.
  - len=0 -> o_valid the cycle after start, o_data=0.
- Handshake: i_valid toggles 1,0,1,1 during len=3 -> exactly 3 beats accumulated. Then i_ready=0 for 3 cycles -> o_data/o_valid stable, and i_start pulses during OUT are ignored.
- Reset: assert i_rst_n=0 after 2 of 4 beats -> all outputs 0 immediately. A new job after release accumulates from acc=0.
